// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// fifo_reader_pkg: shared state encoding and output-buffer sizing for fifo_reader.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_WIDTH = $clog2(BUF_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/fifo_rd_buf2.sv
`default_nettype none
// fifo_rd_buf2: small in-order output buffer; capture and drain may occur in the same cycle.
module fifo_rd_buf2
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int PTR_WIDTH = $clog2(BUF_DEPTH);
  localparam logic [PTR_WIDTH-1:0] LAST = PTR_WIDTH'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_WIDTH-1:0]  head_ptr;
  logic [PTR_WIDTH-1:0]  tail_ptr;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count != CNT_WIDTH'(BUF_DEPTH)) || pop);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[head_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        mem[tail_ptr] <= push_data;
        tail_ptr      <= next_ptr(tail_ptr);
      end
      if (do_pop) head_ptr <= next_ptr(head_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// fifo_reader: pops a commanded number of words from a synchronous FIFO and
// forwards them in order on a valid/ready stream, tolerating write-priority drops.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  rd_count,
  output logic                  fifo_rd,
  input  logic                  fifo_wr,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  localparam int OCC_WIDTH = CNT_WIDTH + 1;

  state_t                state;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  pend;
  logic [CNT_WIDTH-1:0]  buf_cnt;
  logic                  drain;
  logic                  pop_ok;
  logic                  buf_empty_next;
  logic [OCC_WIDTH-1:0]  occupancy;

  assign drain = m_valid && m_ready;

  // Words held plus the one in flight, after this cycle's drain; a read is only
  // issued if its data is guaranteed a slot when it lands.
  assign occupancy = {1'b0, buf_cnt} + OCC_WIDTH'(pend) - OCC_WIDTH'(drain);

  assign fifo_rd = (state == RUN) && (remaining != '0) && !fifo_empty
                   && (occupancy < OCC_WIDTH'(BUF_DEPTH));

  // The FIFO favours an accepted write and silently drops a concurrent read.
  assign pop_ok = fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full);

  assign m_valid = (buf_cnt != '0);

  assign buf_empty_next = (buf_cnt == '0) || ((buf_cnt == CNT_WIDTH'(1)) && drain);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      rd_count  <= '0;
      pend      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pend <= pop_ok;
      if (pop_ok) begin
        remaining <= remaining - LEN_WIDTH'(1);
        rd_count  <= rd_count + LEN_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            remaining <= len;
            rd_count  <= '0;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (pop_ok && (remaining == LEN_WIDTH'(1))) state <= FLUSH;
        end
        FLUSH: begin
          if (!pend && buf_empty_next) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_rd_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pend),
    .push_data (fifo_dout),
    .pop       (drain),
    .count     (buf_cnt),
    .head      (m_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// tb_fifo_reader: directed bench driving fifo_reader against a behavioural synchronous FIFO.
module tb_fifo_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] len;
  logic       busy;
  logic       done;
  logic [7:0] rd_count;
  logic       fifo_rd;
  logic       fifo_wr;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic [7:0] fifo_din;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       fclr;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int c0          = 0;

  // writer schedule and ready pattern, applied once per cycle by step()
  int   wr_at     = 0;
  int   wr_left   = 0;
  logic [7:0] wr_val = 8'h00;
  bit   rdy_toggle = 0;
  bit   rdy_level  = 1;

  // monitor state
  logic [7:0] got[$];
  int   got_cyc[$];
  int   rd_empty_err = 0;
  int   rd_total     = 0;
  int   acc_total    = 0;
  int   done_cnt     = 0;
  int   max_cnt      = 0;
  int   stab_err     = 0;
  bit   prev_stall   = 0;
  logic [7:0] prev_data = 8'h00;

  fifo_reader #(
    .DATA_WIDTH (8),
    .LEN_WIDTH  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .rd_count   (rd_count),
    .fifo_rd    (fifo_rd),
    .fifo_wr    (fifo_wr),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: write wins over a same-cycle read, one-cycle read latency.
  logic [7:0] fmem [16];
  logic [3:0] fwp, frp;
  logic [4:0] fcount;
  assign fifo_empty = (fcount == 5'd0);
  assign fifo_full  = (fcount == 5'd16);

  always @(posedge clk) begin
    if (fclr) begin
      fwp <= 4'd0; frp <= 4'd0; fcount <= 5'd0;
    end else if (fifo_wr && !fifo_full) begin
      fmem[fwp] <= fifo_din; fwp <= fwp + 4'd1; fcount <= fcount + 5'd1;
    end else if (fifo_rd && !fifo_empty) begin
      fifo_dout <= fmem[frp]; frp <= frp + 4'd1; fcount <= fcount - 5'd1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        got_cyc.push_back(cyc);
      end
      if (fifo_rd && fifo_empty) rd_empty_err++;
      if (fifo_rd) rd_total++;
      if (fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full)) acc_total++;
      if (done) done_cnt++;
      if (int'(dut.buf_cnt) > max_cnt) max_cnt = int'(dut.buf_cnt);
      if (prev_stall && (!m_valid || m_data != prev_data)) stab_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      assert (dut.buf_cnt <= 2) else $error("buf_cnt above 2: %0d", dut.buf_cnt);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (wr_left > 0 && cyc >= wr_at) begin
      fifo_wr  = 1'b1;
      fifo_din = wr_val;
      wr_val   = wr_val + 8'd1;
      wr_left--;
    end else begin
      fifo_wr = 1'b0;
    end
    if (rdy_toggle) m_ready = ~m_ready;
    else            m_ready = rdy_level;
    start = 1'b0;
  endtask

  task automatic fifo_clear();
    fclr = 1'b1;
    step();
    fclr = 1'b0;
  endtask

  task automatic preload(input logic [7:0] base, input int n);
    wr_at   = cyc + 1;
    wr_left = n;
    wr_val  = base;
    repeat (n + 1) step();
  endtask

  task automatic clr_mon();
    got.delete();
    got_cyc.delete();
    rd_empty_err = 0; rd_total = 0; acc_total = 0;
    done_cnt = 0; max_cnt = 0; stab_err = 0; prev_stall = 0;
  endtask

  task automatic start_xfer(input logic [7:0] l);
    step();
    start = 1'b1;
    len   = l;
    c0    = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget, output int dcyc);
    bit seen;
    seen = 0;
    dcyc = -1;
    for (int k = 0; k < budget && !seen; k++) begin
      step();
      @(negedge clk);
      if (done) begin
        seen = 1;
        dcyc = cyc;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic check_words(input string tag, input logic [7:0] base, input int n);
    check({tag, "_word_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      check({tag, "_word"}, got[i], 32'(base + 8'(i)));
  endtask

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; len = 8'd0; m_ready = 1'b1;
    fifo_wr = 1'b0; fifo_din = 8'd0; fclr = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    fclr  = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_count", rd_count, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);

    // basic: 5 words, full-rate drain
    fifo_clear(); preload(8'h10, 5); clr_mon();
    start_xfer(8'd5);
    wait_done("basic", 40, dc);
    check("basic_done_cyc", dc - c0, 8);
    step(); @(negedge clk);
    check("basic_busy_after", busy, 0);
    check_words("basic", 8'h10, 5);
    if (got_cyc.size() == 5) begin
      check("basic_first_cyc", got_cyc[0] - c0, 3);
      check("basic_last_cyc", got_cyc[4] - c0, 7);
    end
    check("basic_rd_count", rd_count, 5);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_fifo_empty", fifo_empty, 1);

    // backpressure: ready toggling every cycle
    fifo_clear(); preload(8'h20, 8); clr_mon();
    rdy_toggle = 1;
    start_xfer(8'd8);
    wait_done("bp", 80, dc);
    step(); @(negedge clk);
    rdy_toggle = 0; rdy_level = 1;
    check_words("bp", 8'h20, 8);
    check("bp_rd_count", rd_count, 8);
    check("bp_buf_bound", 32'(max_cnt <= 2), 1);
    check("bp_rd_while_empty", rd_empty_err, 0);
    check("bp_stability", stab_err, 0);
    check("bp_done_cnt", done_cnt, 1);

    // write collision: writer active in cycles 1..3
    fifo_clear(); preload(8'h30, 4); clr_mon();
    start_xfer(8'd4);
    wr_at = c0 + 1; wr_left = 3; wr_val = 8'h40;
    for (int k = 1; k <= 3; k++) begin
      step(); @(negedge clk);
      check("coll_rd_count_held", rd_count, 0);
      if (k == 1) check("coll_rd_issued", fifo_rd, 1);
    end
    wait_done("coll", 40, dc);
    check("coll_done_cyc", dc - c0, 10);
    step(); @(negedge clk);
    check_words("coll", 8'h30, 4);
    check("coll_rd_count", rd_count, 4);
    check("coll_accepted", acc_total, 4);
    check("coll_fifo_left", fcount, 3);
    clr_mon();
    start_xfer(8'd3);
    wait_done("coll2", 40, dc);
    step(); @(negedge clk);
    check_words("coll2", 8'h40, 3);
    check("coll2_fifo_empty", fifo_empty, 1);

    // underflow stall: 2 words now, 2 more written at cycle 10
    fifo_clear(); preload(8'h50, 2); clr_mon();
    start_xfer(8'd4);
    wr_at = c0 + 10; wr_left = 2; wr_val = 8'h52;
    repeat (8) step();
    @(negedge clk);
    check("uf_busy_stalled", busy, 1);
    check("uf_rd_stalled", fifo_rd, 0);
    wait_done("uf", 60, dc);
    step(); @(negedge clk);
    check_words("uf", 8'h50, 4);
    check("uf_rd_count", rd_count, 4);
    check("uf_rd_while_empty", rd_empty_err, 0);
    check("uf_done_cnt", done_cnt, 1);

    // zero length
    fifo_clear(); clr_mon();
    start_xfer(8'd0);
    wait_done("zero", 10, dc);
    check("zero_done_cyc", dc - c0, 1);
    check("zero_busy_in_done", busy, 1);
    step(); @(negedge clk);
    check("zero_busy_after", busy, 0);
    check("zero_no_reads", rd_total, 0);
    check("zero_rd_count", rd_count, 0);

    // start during RUN is ignored
    fifo_clear(); preload(8'h60, 5); clr_mon();
    start_xfer(8'd2);
    step(); start = 1'b1; len = 8'd3;
    wait_done("ign", 30, dc);
    repeat (3) step();
    @(negedge clk);
    check_words("ign", 8'h60, 2);
    check("ign_rd_count", rd_count, 2);
    check("ign_fifo_left", fcount, 3);
    check("ign_idle", busy, 0);

    // reset mid-transfer with two words buffered
    fifo_clear(); preload(8'h80, 6); clr_mon();
    rdy_level = 0;
    start_xfer(8'd6);
    repeat (5) step();
    @(negedge clk);
    check("mrst_buffered", m_valid, 1);
    check("mrst_rd_count_pre", rd_count, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_rd_count", rd_count, 0);
    check("mrst_fifo_rd", fifo_rd, 0);
    check("mrst_m_valid", m_valid, 0);
    check("mrst_m_data", m_data, 0);
    check("mrst_fifo_left", fcount, 4);
    rdy_level = 1;
    clr_mon();
    start_xfer(8'd4);
    wait_done("mrst2", 40, dc);
    check("mrst2_done_cyc", dc - c0, 7);
    step(); @(negedge clk);
    check_words("mrst2", 8'h82, 4);
    check("mrst2_rd_count", rd_count, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_reader.md
# fifo_reader

Read-side master for the synchronous `FIFO` block. On a `start` command it pops exactly `len` words from the FIFO and forwards them in order on a valid/ready stream. It tracks the FIFO's one-cycle read latency and its write-over-read priority, so no word is lost or duplicated under downstream backpressure. It sits between the FIFO's `rd`/`dout`/`empty` side and any stream consumer, and shares the FIFO's clock.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `LEN_WIDTH`, 8, width of `len` and `rd_count`.
- `clk` in 1: single clock, shared with the FIFO.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: command strobe; honoured only in IDLE.
- `len` in LEN_WIDTH: number of words to pop; sampled with `start`.
- `busy` out 1: high in RUN, FLUSH and DONE.
- `done` out 1: one-cycle pulse when the transfer completes.
- `rd_count` out LEN_WIDTH: words accepted from the FIFO this transfer; holds its value until the next `start`.
- `fifo_rd` out 1: drives the FIFO `rd`.
- `fifo_wr` in 1: the FIFO's `wr`, monitored.
- `fifo_full` in 1: the FIFO's `full`.
- `fifo_empty` in 1: the FIFO's `empty`.
- `fifo_dout` in DATA_WIDTH: the FIFO's `dout`.
- `m_valid` out 1, `m_data` out DATA_WIDTH, `m_ready` in 1: output stream.

## Operation
- **Pop acceptance.** A pop is accepted when `fifo_rd && !fifo_empty && !(fifo_wr && !fifo_full)`. The FIFO gives an accepted write priority and drops a read issued in the same cycle.
  - Only accepted pops decrement `remaining` and increment `rd_count`.
  - A dropped read is simply retried in a later cycle.
- **State machine.**
  - IDLE: on `start`, load `remaining=len`, clear `rd_count`, go to RUN. If `len==0`, go directly to DONE.
  - RUN: issue reads. When the last accepted pop occurs (`remaining` goes 1→0), go to FLUSH.
  - FLUSH: no reads. When `pend==0` and the buffer is empty, go to DONE.
  - DONE: `done=1` for one cycle, then IDLE.
- **Read issue.** `fifo_rd = (state==RUN) && remaining!=0 && !fifo_empty && (buf_cnt + pend - (m_valid&&m_ready)) < 2`.
  - `fifo_rd` is never asserted while `fifo_empty` is high.
- **Pending flag.** `pend` is a register set by an accepted pop. In the following cycle `fifo_dout` is captured into the buffer tail.
- **Output buffer.** A 2-entry in-order buffer. `m_valid = buf_cnt!=0`, and `m_data` is the head entry.
  - Capture and drain in the same cycle are both performed.
  - `buf_cnt` never exceeds 2. Overflow is impossible by construction; the bench checks this with an assertion.
- **Command handling.** `start` in any state other than IDLE is ignored. `len` is sampled only with an honoured `start`.
- **Counter widths.** `remaining` and `rd_count` are LEN_WIDTH bits. The maximum transfer is 2^LEN_WIDTH−1 words, and neither counter wraps.
- **Reset.** Reset is synchronous, and mid-transfer reset aborts the transfer.
  - State returns to IDLE; buffer, `pend`, `remaining` and `rd_count` clear.
  - Words already popped but not delivered are discarded. FIFO contents are unaffected.

## Timing
- **Reset values.** `busy=0`, `done=0`, `rd_count=0`, `fifo_rd=0`, `m_valid=0`, `m_data=0`.
- **First-word latency.** With `start` honoured in cycle 0 and data available:
  - `fifo_rd` first asserts in cycle 1.
  - `fifo_dout` is valid in cycle 2 and captured at the end of cycle 2.
  - `m_valid` rises in cycle 3.
- **Throughput.** Steady state is one word per cycle with `m_ready=1` and no write collisions.
- **Backpressure.** With `m_ready=0`, at most 2 words are held. `fifo_rd` drops within one cycle of the buffer plus in-flight count reaching 2.
- **Completion.** `done` asserts in the cycle after the last word handshakes on the stream. `busy` drops the cycle after `done`.
- **Zero length.** With `len==0`: `done` in cycle 1, no `fifo_rd`.
- **Stream stability.** `m_data` is stable while `m_valid && !m_ready`.

## Structure
- Package `fifo_reader_pkg`:
  - `state_t` enum {IDLE, RUN, FLUSH, DONE};
  - `BUF_DEPTH=2` constant.
- Sub-module `fifo_rd_buf2`: the 2-entry in-order buffer with push, pop, count, head and tail. The top level holds the FSM, counters, `pend` and the pop-acceptance logic.

## Test plan
- **Basic transfer.** FIFO preloaded with 0x10..0x14, `len=5`, `m_ready=1` → `m_data` 0x10..0x14 on consecutive cycles starting at cycle 3; `rd_count=5`; one `done` pulse; FIFO `empty`.
- **Backpressure.** FIFO holds 8 words, `len=8`, `m_ready` toggling 1/0 → all 8 words delivered in order; `buf_cnt ≤ 2` throughout; no `fifo_rd` while `fifo_empty`.
- **Write collision.** Writer drives `fifo_wr=1` (FIFO not full) during cycles 1–3 of a `len=4` read → no pops accepted in cycles 1–3; `rd_count` stays 0 through cycle 3, then reaches 4; no duplicated or lost word.
- **Underflow stall.** FIFO holds 2 words, `len=4`; 2 more words are written 10 cycles later → reader stalls with `busy=1` and `fifo_rd=0` while empty, then completes with 4 words and `done`.
- **Zero length and ignored start.** `len=0` → `done` in cycle 1, no reads. `start` pulsed during RUN with `len=3` → ignored, and the original `len` completes.
- **Reset mid-transfer.** `rst_n=0` for one cycle during RUN with 2 words buffered → next cycle all outputs at reset values, `m_valid=0`, state IDLE; the following `start` operates normally.
